// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Cyclic "first set bit at or after the pointer" selector, purely combinational.
// Built as two lowest-set-bit priority encoders. One works on the requests at or
// above the pointer, and one works on all requests. It picks the upper one if any
// request is there, otherwise it wraps to the lowest request overall.
//
// Parameters
//   N       number of request lines (N >= 2)
// Ports
//   mask    [N-1:0] request lines (1 = candidate)
//   ptr_oh  [N-1:0] one-hot starting position of the search
//   grant   [N-1:0] one-hot selected line, all zeros when mask is empty
// -----------------------------------------------------------------------------
module rr_select #(
    parameter int N = 4
) (
    input  logic [N-1:0] mask,
    input  logic [N-1:0] ptr_oh,
    output logic [N-1:0] grant
);

    logic [N-1:0] upper_mask;
    logic [N-1:0] masked_req;
    logic [N-1:0] masked_grant;
    logic [N-1:0] unmasked_grant;

    always_comb begin
        // ptr_oh - 1 sets every bit below the pointer; inverting keeps the
        // pointer position and everything above it.
        upper_mask     = ~(ptr_oh - N'(1));
        masked_req     = mask & upper_mask;
        // x & -x isolates the lowest set bit.
        masked_grant   = masked_req & (~masked_req + N'(1));
        unmasked_grant = mask & (~mask + N'(1));
        grant          = (|masked_req) ? masked_grant : unmasked_grant;
    end

endmodule

// File: rtl/rr_dispatcher.sv
// -----------------------------------------------------------------------------
// rr_dispatcher
// Spreads a single input beat stream over N output channels in round-robin
// order. Each channel has one output register. A channel takes a new beat only
// when its register is empty, and full channels are skipped rather than waited
// on. s_ready depends only on registered state and rst_n, so there is no path
// from m_ready to s_ready.
//
// Optional feature: define RR_DISPATCHER_PACKET_EN for packet mode. That adds
// s_last/m_last. After a non-last beat is accepted, the target channel stays
// locked until the s_last beat is accepted.
//
// Parameters
//   N        number of output channels (N >= 2)
//   W        data width
// Ports
//   clk      clock, rising edge
//   rst_n    synchronous active-low reset
//   s_data   [W-1:0]   input beat
//   s_valid  input beat present
//   s_last   (packet mode only) last beat of packet
//   s_ready  beat accepted this cycle when s_valid is high
//   m_data   [N*W-1:0] channel i data on bits [i*W +: W]
//   m_valid  [N-1:0]   channel i holds a beat
//   m_last   (packet mode only) [N-1:0] channel i beat is last of its packet
//   m_ready  [N-1:0]   channel i consumer accepts
// -----------------------------------------------------------------------------
module rr_dispatcher #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   s_data,
    input  logic           s_valid,
`ifdef RR_DISPATCHER_PACKET_EN
    input  logic           s_last,
`endif
    output logic           s_ready,
    output logic [N*W-1:0] m_data,
    output logic [N-1:0]   m_valid,
`ifdef RR_DISPATCHER_PACKET_EN
    output logic [N-1:0]   m_last,
`endif
    input  logic [N-1:0]   m_ready
);

    logic [N-1:0] valid_reg;
    logic [N-1:0] valid_next;
    logic [W-1:0] data_reg [N];
    // The round-robin pointer is kept one-hot because that is how the selector consumes it.
    logic [N-1:0] ptr_reg;
    logic [N-1:0] ptr_next;

    logic [N-1:0] eligible;
    logic [N-1:0] rr_grant;
    logic [N-1:0] target;
    logic [N-1:0] target_rot;
    logic         any_eligible;
    logic         accept;

    assign eligible = ~valid_reg;

    rr_select #(
        .N(N)
    ) u_select (
        .mask   (eligible),
        .ptr_oh (ptr_reg),
        .grant  (rr_grant)
    );

    // The channel after the target is the pointer position for the next search.
    assign target_rot = {target[N-2:0], target[N-1]};

`ifdef RR_DISPATCHER_PACKET_EN
    logic         lock_active_reg;
    logic         lock_active_next;
    logic [N-1:0] lock_reg;
    logic [N-1:0] lock_next;
    logic [N-1:0] last_reg;

    // While a packet is open, only its channel can be used. We stall on that
    // channel instead of skipping it, so the packet beats stay together.
    assign target           = lock_active_reg ? lock_reg : rr_grant;
    assign any_eligible     = lock_active_reg ? ~|(valid_reg & lock_reg) : |eligible;
    assign ptr_next         = (accept & s_last) ? target_rot : ptr_reg;
    assign lock_active_next = accept ? ~s_last : lock_active_reg;
    assign lock_next        = accept ? target : lock_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_active_reg <= 1'b0;
            lock_reg        <= N'(1);
        end else begin
            lock_active_reg <= lock_active_next;
            lock_reg        <= lock_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (accept && target[i]) begin
                last_reg[i] <= s_last;
            end
        end
    end

    assign m_last = last_reg;
`else
    assign target       = rr_grant;
    assign any_eligible = |eligible;
    assign ptr_next     = accept ? target_rot : ptr_reg;
`endif

    assign s_ready = rst_n & any_eligible;
    assign accept  = s_valid & s_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            // A new beat only goes to an empty channel, so loading and draining
            // never hit the same channel on the same edge.
            assign valid_next[gi]       = (accept & target[gi]) | (valid_reg[gi] & ~m_ready[gi]);
            assign m_data[gi*W +: W]    = data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= '0;
            ptr_reg   <= N'(1);
        end else begin
            valid_reg <= valid_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Data is not reset. Consumers qualify it with m_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (accept && target[i]) begin
                data_reg[i] <= s_data;
            end
        end
    end

    assign m_valid = valid_reg;

endmodule

// File: tb/tb_rr_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_rr_dispatcher
// Self-checking bench for rr_dispatcher with N=4, W=8. The behavioural model
// keeps per-channel occupancy in arrays. Each beat goes to the first empty
// channel found by searching cyclically from an integer pointer. Directed
// scenarios are followed by a randomized run, and packet scenarios are added
// when RR_DISPATCHER_PACKET_EN is defined.
// -----------------------------------------------------------------------------
module tb_rr_dispatcher;

    localparam int N = 4;
    localparam int W = 8;
`ifdef RR_DISPATCHER_PACKET_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   s_data;
    logic           s_valid;
    logic           s_last;
    logic           s_ready;
    logic [N*W-1:0] m_data;
    logic [N-1:0]   m_valid;
    logic [N-1:0]   m_ready;
`ifdef RR_DISPATCHER_PACKET_EN
    logic [N-1:0]   m_last;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_dispatcher #(
        .N(N),
        .W(W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
`ifdef RR_DISPATCHER_PACKET_EN
        .s_last  (s_last),
`endif
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
`ifdef RR_DISPATCHER_PACKET_EN
        .m_last  (m_last),
`endif
        .m_ready (m_ready)
    );

    // ---------------- reference model ----------------
    bit         mdl_valid [N];
    logic [7:0] mdl_data  [N];
    bit         mdl_last  [N];
    int         mdl_ptr     = 0;
    bit         mdl_lock    = 0;
    int         mdl_lock_ch = 0;

    function automatic bit mdl_ready();
        if (!rst_n) return 1'b0;
        if (PKT && mdl_lock) return !mdl_valid[mdl_lock_ch];
        for (int i = 0; i < N; i++) if (!mdl_valid[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int mdl_target();
        if (PKT && mdl_lock) return mdl_lock_ch;
        for (int off = 0; off < N; off++) begin
            if (!mdl_valid[(mdl_ptr + off) % N]) return (mdl_ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] mdl_mvalid();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = mdl_valid[i];
        return v;
    endfunction

    // Advance the model by one clock edge, using the inputs currently driven.
    function automatic void mdl_edge();
        bit acc;
        int k;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mdl_valid[i] = 1'b0;
            mdl_ptr  = 0;
            mdl_lock = 1'b0;
            return;
        end
        acc = s_valid && mdl_ready();
        k   = mdl_target();
        for (int i = 0; i < N; i++) if (mdl_valid[i] && m_ready[i]) mdl_valid[i] = 1'b0;
        if (acc) begin
            mdl_valid[k] = 1'b1;
            mdl_data[k]  = s_data;
            mdl_last[k]  = s_last;
            if (!PKT || s_last) begin
                mdl_ptr  = (k + 1) % N;
                mdl_lock = 1'b0;
            end else begin
                mdl_lock    = 1'b1;
                mdl_lock_ch = k;
            end
        end
    endfunction

    // Model first (pre-edge inputs), then the clock edge, then settle 1 time unit.
    task automatic cycle();
        mdl_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b1;
        m_ready = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_last  = 1'b1;
        m_ready = '0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready);
        end
        cycle();
        checks++;
        if (m_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_m_valid: got %b expected 0000", m_valid);
        end
        rst_n   = 1'b1;
        s_valid = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_s_ready: got %b expected 1", s_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        int exp_ch [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [7:0] beat;
        do_reset();
        m_ready = 4'hF;
        for (int b = 0; b < 8; b++) begin
            beat    = 8'(8'h10 + b);
            s_valid = 1'b1;
            s_data  = beat;
            #1;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++; $display("FAIL rr_s_ready beat %0d: got %b expected 1", b, s_ready);
            end
            cycle();
            checks++;
            if (m_valid[exp_ch[b]] !== 1'b1 || m_data[exp_ch[b]*W +: W] !== beat) begin
                errors++;
                $display("FAIL rr_landing beat %h: ch%0d valid=%b data=%h expected valid=1 data=%h",
                         beat, exp_ch[b], m_valid[exp_ch[b]], m_data[exp_ch[b]*W +: W], beat);
            end
            checks++;
            if (m_valid !== mdl_mvalid()) begin
                errors++; $display("FAIL rr_m_valid beat %h: got %b expected %b", beat, m_valid, mdl_mvalid());
            end
            $display("rr beat %h -> ch%0d", beat, exp_ch[b]);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_skip_full_channel();
        int exp_ch [6] = '{0, 1, 2, 3, 0, 2};
        logic [7:0] beat;
        do_reset();
        m_ready = 4'b1101;
        for (int b = 0; b < 6; b++) begin
            beat    = 8'(8'hA0 + b);
            s_valid = 1'b1;
            s_data  = beat;
            #1;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++; $display("FAIL skip_s_ready beat %h: got %b expected 1", beat, s_ready);
            end
            cycle();
            checks++;
            if (m_valid[exp_ch[b]] !== 1'b1 || m_data[exp_ch[b]*W +: W] !== beat) begin
                errors++;
                $display("FAIL skip_landing beat %h: ch%0d valid=%b data=%h expected valid=1 data=%h",
                         beat, exp_ch[b], m_valid[exp_ch[b]], m_data[exp_ch[b]*W +: W], beat);
            end
            $display("skip beat %h -> ch%0d", beat, exp_ch[b]);
        end
        s_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (m_valid[1] !== 1'b1 || m_data[1*W +: W] !== 8'hA1) begin
                errors++;
                $display("FAIL skip_hold_ch1: valid=%b data=%h expected valid=1 data=a1", m_valid[1], m_data[1*W +: W]);
            end
        end
    endtask

    task automatic test_all_full();
        logic [7:0] beat;
        do_reset();
        m_ready = '0;
        for (int b = 0; b < 4; b++) begin
            beat    = 8'(8'hB0 + b);
            s_valid = 1'b1;
            s_data  = beat;
            cycle();
            checks++;
            if (m_valid[b] !== 1'b1 || m_data[b*W +: W] !== beat) begin
                errors++;
                $display("FAIL full_fill beat %h: ch%0d valid=%b data=%h", beat, b, m_valid[b], m_data[b*W +: W]);
            end
        end
        s_data = 8'hB4;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL full_s_ready: got %b expected 0", s_ready);
        end
        m_ready = 4'b0100;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL full_pulse_s_ready: got %b expected 0", s_ready);
        end
        cycle();
        checks++;
        if (m_valid !== 4'b1011) begin
            errors++; $display("FAIL full_drain_ch2: got %b expected 1011", m_valid);
        end
        m_ready = '0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL full_reopen_s_ready: got %b expected 1", s_ready);
        end
        cycle();
        checks++;
        if (m_valid !== 4'b1111 || m_data[2*W +: W] !== 8'hB4) begin
            errors++; $display("FAIL full_b4_ch2: valid=%b ch2=%h expected 1111/b4", m_valid, m_data[2*W +: W]);
        end
        $display("full beat b4 -> ch2");
        // Drain everything; the next beat reveals the pointer (expected 3).
        s_valid = 1'b0;
        m_ready = 4'hF;
        cycle();
        m_ready = '0;
        s_valid = 1'b1;
        s_data  = 8'hB5;
        cycle();
        checks++;
        if (m_valid !== 4'b1000 || m_data[3*W +: W] !== 8'hB5) begin
            errors++; $display("FAIL full_ptr3: valid=%b ch3=%h expected 1000/b5", m_valid, m_data[3*W +: W]);
        end
        $display("full beat b5 -> ch3");
        s_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_ready = '0;
        for (int b = 0; b < 4; b++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h90 + b);
            cycle();
        end
        s_valid = 1'b0;
        m_ready = 4'b0110;
        cycle();
        checks++;
        if (m_valid !== 4'b1001) begin
            errors++; $display("FAIL mid_setup: got %b expected 1001", m_valid);
        end
        m_ready = '0;
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hC0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_s_ready: got %b expected 0", s_ready);
        end
        cycle();
        checks++;
        if (m_valid !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_m_valid: got %b expected 0000", m_valid);
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if (m_valid !== 4'b0001 || m_data[0 +: W] !== 8'hC0) begin
            errors++; $display("FAIL mid_c0_ch0: valid=%b ch0=%h expected 0001/c0", m_valid, m_data[0 +: W]);
        end
        $display("mid-reset beat c0 -> ch0");
        s_valid = 1'b0;
    endtask

`ifdef RR_DISPATCHER_PACKET_EN
    task automatic test_packet();
        logic [7:0] pkt [3] = '{8'h01, 8'h02, 8'h03};
        int  idx    = 0;
        int  stalls = 0;
        bit  acc;
        do_reset();
        for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
            s_valid = 1'b1;
            s_data  = pkt[idx];
            s_last  = (idx == 2);
            m_ready = {3'b000, cyc[0]};
            #1;
            checks++;
            if (s_ready !== mdl_ready()) begin
                errors++; $display("FAIL pkt_s_ready cyc %0d: got %b expected %b", cyc, s_ready, mdl_ready());
            end
            acc = s_ready;
            if (!acc) stalls++;
            cycle();
            if (acc) begin
                checks++;
                if (m_valid[0] !== 1'b1 || m_data[0 +: W] !== pkt[idx] || m_last[0] !== (idx == 2)) begin
                    errors++;
                    $display("FAIL pkt_beat %h: ch0 valid=%b data=%h last=%b expected 1/%h/%b",
                             pkt[idx], m_valid[0], m_data[0 +: W], m_last[0], pkt[idx], (idx == 2));
                end
                $display("pkt beat %h -> ch0 last=%b", pkt[idx], m_last[0]);
                idx++;
            end
        end
        checks++;
        if (idx != 3) begin
            errors++; $display("FAIL pkt_timeout: beats accepted %0d expected 3", idx);
        end
        checks++;
        if (stalls == 0) begin
            errors++; $display("FAIL pkt_stall: stall cycles %0d expected >0", stalls);
        end
        m_ready = '0;
        s_valid = 1'b1;
        s_data  = 8'h04;
        s_last  = 1'b1;
        cycle();
        checks++;
        if (m_valid[1] !== 1'b1 || m_data[1*W +: W] !== 8'h04 || m_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL pkt_next_ch1: valid=%b data=%h last=%b expected 1/04/1", m_valid[1], m_data[1*W +: W], m_last[1]);
        end
        $display("pkt beat 04 -> ch1");
        s_valid = 1'b0;
    endtask
`endif

    task automatic test_random();
        bit exp_ready;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst_n   = ($urandom_range(0, 63) != 0);
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = 8'($urandom);
            s_last  = ($urandom_range(0, 2) == 0);
            m_ready = 4'($urandom);
            #1;
            exp_ready = mdl_ready();
            checks++;
            if (s_ready !== exp_ready) begin
                errors++; $display("FAIL rand_s_ready cyc %0d: got %b expected %b", c, s_ready, exp_ready);
            end
            cycle();
            checks++;
            if (m_valid !== mdl_mvalid()) begin
                errors++; $display("FAIL rand_m_valid cyc %0d: got %b expected %b", c, m_valid, mdl_mvalid());
            end
            for (int i = 0; i < N; i++) begin
                if (mdl_valid[i]) begin
                    checks++;
                    if (m_data[i*W +: W] !== mdl_data[i]) begin
                        errors++;
                        $display("FAIL rand_m_data cyc %0d ch%0d: got %h expected %h", c, i, m_data[i*W +: W], mdl_data[i]);
                    end
`ifdef RR_DISPATCHER_PACKET_EN
                    checks++;
                    if (m_last[i] !== mdl_last[i]) begin
                        errors++;
                        $display("FAIL rand_m_last cyc %0d ch%0d: got %b expected %b", c, i, m_last[i], mdl_last[i]);
                    end
`endif
                end
            end
        end
        rst_n   = 1'b1;
        s_valid = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b1;
        m_ready = '0;
        for (int i = 0; i < N; i++) begin
            mdl_valid[i] = 1'b0;
            mdl_data[i]  = '0;
            mdl_last[i]  = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_skip_full_channel();
        test_all_full();
        test_reset_mid();
`ifdef RR_DISPATCHER_PACKET_EN
        test_packet();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
